frame_bank_arbiter: RTL and testbench
=====================================

Name: frame_bank_arbiter

Overview:
- Parametrised N-bank frame-buffer arbiter between the camera writer and the VGA reader, both sharing the SDRAM controller clock.
- Hands the writer a free bank after each completed frame and gives the reader the newest complete frame at each reader frame start.
- Supports NUM_BANKS ≥ 3, a configurable synchroniser depth, a hold (freeze) mode, and saturating dropped/repeated-frame statistics.

Parameters:
- NUM_BANKS, 3, number of frame banks; legal range 3..8.
- BANK_W, 2, bank index width; must satisfy 2**BANK_W ≥ NUM_BANKS.
- SYNC_STAGES, 2, flops in each input synchroniser; legal range 2..4.
- CNT_W, 16, width of the statistics counters.

Ports:
- clk  input  1  controller clock.
- rst_133  input  1  asynchronous active-low reset.
- cam_done  input  1  writer frame-complete level/pulse; asynchronous to clk; high ≥ SYNC_STAGES+1 clk cycles.
- vga_start  input  1  reader frame-start level/pulse; asynchronous; same width rule as cam_done.
- freeze  input  1  synchronous; while high the reader keeps its bank.
- clr_stats  input  1  synchronous; clears both counters.
- cam_bank  output  BANK_W  bank the writer fills.
- vga_bank  output  BANK_W  bank the reader scans.
- ready_valid  output  1  an unread complete frame exists.
- ready_bank  output  BANK_W  bank holding that frame.
- vga_new  output  1  one-cycle pulse: vga_bank changed this cycle.
- drop_cnt  output  CNT_W  unread frames overwritten; saturating.
- repeat_cnt  output  CNT_W  reader starts with no new frame; saturating.

Behaviour:
- Reset (async assert, sync release): vga_bank=0, cam_bank=1, ready_bank=0, ready_valid=0, vga_new=0, drop_cnt=0, repeat_cnt=0, synchroniser flops=0.
- Each input passes through SYNC_STAGES flops, then one extra flop for rising-edge detect.
  - Event pulse (wr_ev / rd_ev) is high one cycle.
  - Outputs update on the clock edge after the pulse.
  - Total latency from input edge to output change is SYNC_STAGES+2 cycles, ±1 for asynchrony.
- Free set = all banks < NUM_BANKS excluding vga_bank, cam_bank, and ready_bank when ready_valid=1. Free bank pick = lowest index in the set.
- rd_ev alone:
  - freeze=0, ready_valid=1: vga_bank←ready_bank, ready_valid←0, vga_new=1.
  - freeze=0, ready_valid=0: repeat_cnt+1; vga_bank unchanged.
  - freeze=1: no bank change, no counter change.
- wr_ev alone:
  - If ready_valid=1: drop_cnt+1 (old ready bank is released).
  - Then ready_bank←cam_bank, ready_valid←1, cam_bank←lowest bank ≠ vga_bank and ≠ old cam_bank.
- Simultaneous rd_ev and wr_ev: resolve the read first, then the write, in the same cycle.
  - The reader takes the old ready frame if one is valid.
  - The writer's finished bank becomes ready (ready_valid=1).
  - cam_bank gets the lowest bank not equal to the new vga_bank or the new ready_bank.
  - No drop is counted when the reader consumed the old ready frame; otherwise the wr_ev-alone rule applies.
- Invariants checked in all cycles:
  - vga_bank ≠ cam_bank.
  - When ready_valid=1, ready_bank differs from both.
  - All bank indices < NUM_BANKS.
  - With NUM_BANKS ≥ 3 a free bank always exists.
- Counters: saturate at all-ones. clr_stats has priority over an increment in the same cycle.
- freeze is sampled only on rd_ev cycles. Writer rotation continues while frozen.
- Reset mid-frame: immediate return to reset values. Events whose edges are still in flight in the synchronisers are lost.
- Input held high: produces only one event, no retrigger.

Test Plan:
- Reset, then three cam_done pulses, no vga_start -> cam_bank sequence 1→2→1→2; ready_bank 1,2,1; drop_cnt=2; vga_bank=0.
- Reset, cam_done, then vga_start -> ready_valid=1, ready_bank=1, cam_bank=2; then vga_bank=1, vga_new one cycle, ready_valid=0, repeat_cnt=0.
- Reset, two vga_start, no cam_done -> vga_bank=0, repeat_cnt=2, vga_new never asserted.
- After cam_done (ready=1, cam=2), cam_done and vga_start synchronised into the same cycle -> vga_bank=1, ready_bank=2, cam_bank=0, ready_valid=1, drop_cnt=0.
- NUM_BANKS=5, freeze=1, four cam_done pulses then vga_start -> vga_bank stays 0; cam_bank 1→2→1→2→1 (lowest free bank excluding vga 0 and the new ready bank each time); drop_cnt=3, repeat_cnt=0; after freeze=0, the next vga_start gives vga_bank=2 (the last ready bank).
- CNT_W=2, five vga_start with no frames -> repeat_cnt saturates at 3; clr_stats plus vga_start in the same cycle -> 0; rst_133 low mid-sequence -> all outputs return to reset values within the same cycle.

Source files
------------

// File: rtl/frame_bank_arbiter.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : frame_bank_arbiter                                           |
// | Description : N-bank frame-buffer rotation between a camera writer and a   |
// |               VGA reader, with input synchronisers and frame statistics.   |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
module frame_bank_arbiter #(
    parameter int NUM_BANKS   = 3,
    parameter int BANK_W      = 2,
    parameter int SYNC_STAGES = 2,
    parameter int CNT_W       = 16
) (
    input  logic              clk,
    input  logic              rst_133,
    input  logic              cam_done,
    input  logic              vga_start,
    input  logic              freeze,
    input  logic              clr_stats,
    output logic [BANK_W-1:0] cam_bank,
    output logic [BANK_W-1:0] vga_bank,
    output logic              ready_valid,
    output logic [BANK_W-1:0] ready_bank,
    output logic              vga_new,
    output logic [CNT_W-1:0]  drop_cnt,
    output logic [CNT_W-1:0]  repeat_cnt
);

    localparam logic [CNT_W-1:0]  C_CNT_MAX  = '1;
    localparam logic [CNT_W-1:0]  C_CNT_ONE  = {{(CNT_W-1){1'b0}}, 1'b1};
    localparam logic [BANK_W-1:0] C_VGA_RST  = '0;
    localparam logic [BANK_W-1:0] C_CAM_RST  = {{(BANK_W-1){1'b0}}, 1'b1};

    // Synchroniser chains plus one delay flop each for rising-edge detection
    logic [SYNC_STAGES-1:0] r_cam_sync;
    logic [SYNC_STAGES-1:0] r_vga_sync;
    logic                   r_cam_dly;
    logic                   r_vga_dly;
    logic                   w_wr_ev;
    logic                   w_rd_ev;

    logic [BANK_W-1:0]      r_cam_bank;
    logic [BANK_W-1:0]      r_vga_bank;
    logic [BANK_W-1:0]      r_ready_bank;
    logic                   r_ready_valid;
    logic                   r_vga_new;
    logic [CNT_W-1:0]       r_drop_cnt;
    logic [CNT_W-1:0]       r_repeat_cnt;

    logic [BANK_W-1:0]      w_vga_nxt;
    logic                   w_rv_mid;
    logic                   w_vga_new_nxt;
    logic                   w_rep_inc;
    logic [BANK_W-1:0]      w_free_bank;
    logic                   w_free_found;
    logic [BANK_W-1:0]      w_cam_nxt;
    logic [BANK_W-1:0]      w_rdy_nxt;
    logic                   w_rv_nxt;
    logic                   w_drop_inc;

    always_ff @(posedge clk or negedge rst_133) begin
        if (!rst_133) begin
            r_cam_sync <= '0;
            r_vga_sync <= '0;
            r_cam_dly  <= 1'b0;
            r_vga_dly  <= 1'b0;
        end else begin
            r_cam_sync <= {r_cam_sync[SYNC_STAGES-2:0], cam_done};
            r_vga_sync <= {r_vga_sync[SYNC_STAGES-2:0], vga_start};
            r_cam_dly  <= r_cam_sync[SYNC_STAGES-1];
            r_vga_dly  <= r_vga_sync[SYNC_STAGES-1];
        end
    end

    assign w_wr_ev = r_cam_sync[SYNC_STAGES-1] & ~r_cam_dly;
    assign w_rd_ev = r_vga_sync[SYNC_STAGES-1] & ~r_vga_dly;

    // Read side resolves first so a simultaneous write sees the post-read state
    always_comb begin
        w_vga_nxt     = r_vga_bank;
        w_rv_mid      = r_ready_valid;
        w_vga_new_nxt = 1'b0;
        w_rep_inc     = 1'b0;
        if (w_rd_ev && !freeze) begin
            if (r_ready_valid) begin
                w_vga_nxt     = r_ready_bank;
                w_rv_mid      = 1'b0;
                w_vga_new_nxt = 1'b1;
            end else begin
                w_rep_inc     = 1'b1;
            end
        end
    end

    // The finishing cam bank becomes ready, so only the reader and it are excluded
    always_comb begin
        w_free_bank  = '0;
        w_free_found = 1'b0;
        for (int i = 0; i < NUM_BANKS; i++) begin
            if (!w_free_found && (BANK_W'(i) != w_vga_nxt) && (BANK_W'(i) != r_cam_bank)) begin
                w_free_bank  = BANK_W'(i);
                w_free_found = 1'b1;
            end
        end
    end

    always_comb begin
        w_cam_nxt  = r_cam_bank;
        w_rdy_nxt  = r_ready_bank;
        w_rv_nxt   = w_rv_mid;
        w_drop_inc = 1'b0;
        if (w_wr_ev) begin
            w_drop_inc = w_rv_mid;
            w_rdy_nxt  = r_cam_bank;
            w_rv_nxt   = 1'b1;
            w_cam_nxt  = w_free_bank;
        end
    end

    always_ff @(posedge clk or negedge rst_133) begin
        if (!rst_133) begin
            r_vga_bank    <= C_VGA_RST;
            r_cam_bank    <= C_CAM_RST;
            r_ready_bank  <= '0;
            r_ready_valid <= 1'b0;
            r_vga_new     <= 1'b0;
        end else begin
            r_vga_bank    <= w_vga_nxt;
            r_cam_bank    <= w_cam_nxt;
            r_ready_bank  <= w_rdy_nxt;
            r_ready_valid <= w_rv_nxt;
            r_vga_new     <= w_vga_new_nxt;
        end
    end

    // Statistics saturate; a clear wins over a coincident increment
    always_ff @(posedge clk or negedge rst_133) begin
        if (!rst_133) begin
            r_drop_cnt   <= '0;
            r_repeat_cnt <= '0;
        end else if (clr_stats) begin
            r_drop_cnt   <= '0;
            r_repeat_cnt <= '0;
        end else begin
            if (w_drop_inc && (r_drop_cnt != C_CNT_MAX)) begin
                r_drop_cnt <= r_drop_cnt + C_CNT_ONE;
            end
            if (w_rep_inc && (r_repeat_cnt != C_CNT_MAX)) begin
                r_repeat_cnt <= r_repeat_cnt + C_CNT_ONE;
            end
        end
    end

    assign cam_bank    = r_cam_bank;
    assign vga_bank    = r_vga_bank;
    assign ready_bank  = r_ready_bank;
    assign ready_valid = r_ready_valid;
    assign vga_new     = r_vga_new;
    assign drop_cnt    = r_drop_cnt;
    assign repeat_cnt  = r_repeat_cnt;

endmodule
`default_nettype wire

// File: tb/tb_frame_bank_arbiter.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : tb_frame_bank_arbiter                                        |
// | Description : Bench for frame_bank_arbiter: 3-bank/16-bit and 5-bank/2-bit |
// |               instances checked against a frame-level model every cycle.   |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
module tb_frame_bank_arbiter;

    localparam int S_A    = 2;
    localparam int S_B    = 3;
    localparam int HOLD   = 6;
    localparam int GAP    = 10;

    typedef struct packed {
        int vga;
        int cam;
        int rdy;
        int rv;
        int vnew;
        int drop;
        int rep;
    } mst_t;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst_a = 1'b0, cam_a = 1'b0, vga_a = 1'b0, frz_a = 1'b0, clr_a = 1'b0;
    logic [1:0]  cam_bank_a, vga_bank_a, rdy_bank_a;
    logic        rv_a, vnew_a;
    logic [15:0] drop_a, rep_a;

    logic        rst_b = 1'b0, cam_b = 1'b0, vga_b = 1'b0, frz_b = 1'b0, clr_b = 1'b0;
    logic [2:0]  cam_bank_b, vga_bank_b, rdy_bank_b;
    logic        rv_b, vnew_b;
    logic [1:0]  drop_b, rep_b;

    frame_bank_arbiter #(.NUM_BANKS(3), .BANK_W(2), .SYNC_STAGES(S_A), .CNT_W(16)) u_dut_a (
        .clk(clk), .rst_133(rst_a), .cam_done(cam_a), .vga_start(vga_a),
        .freeze(frz_a), .clr_stats(clr_a), .cam_bank(cam_bank_a), .vga_bank(vga_bank_a),
        .ready_valid(rv_a), .ready_bank(rdy_bank_a), .vga_new(vnew_a),
        .drop_cnt(drop_a), .repeat_cnt(rep_a)
    );

    frame_bank_arbiter #(.NUM_BANKS(5), .BANK_W(3), .SYNC_STAGES(S_B), .CNT_W(2)) u_dut_b (
        .clk(clk), .rst_133(rst_b), .cam_done(cam_b), .vga_start(vga_b),
        .freeze(frz_b), .clr_stats(clr_b), .cam_bank(cam_bank_b), .vga_bank(vga_bank_b),
        .ready_valid(rv_b), .ready_bank(rdy_bank_b), .vga_new(vnew_b),
        .drop_cnt(drop_b), .repeat_cnt(rep_b)
    );

    int n_chk  = 0;
    int n_fail = 0;
    bit cmp_en = 1'b0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    function automatic mst_t reset_state();
        mst_t s;
        s.vga = 0; s.cam = 1; s.rdy = 0; s.rv = 0; s.vnew = 0; s.drop = 0; s.rep = 0;
        return s;
    endfunction

    function automatic int lowest_free(input int nb, input int x, input int y);
        for (int i = 0; i < nb; i++) begin
            if (i != x && i != y) return i;
        end
        return -1;
    endfunction

    // One frame-level step: reader consumes first, then writer publishes its bank
    function automatic mst_t step(input mst_t s, input bit wr, input bit rd, input bit frz,
                                  input bit clr, input int nb, input int cmax);
        mst_t n;
        bit   dinc;
        bit   rinc;
        n = s; n.vnew = 0; dinc = 1'b0; rinc = 1'b0;
        if (rd && !frz) begin
            if (s.rv != 0) begin
                n.vga = s.rdy; n.rv = 0; n.vnew = 1;
            end else begin
                rinc = 1'b1;
            end
        end
        if (wr) begin
            dinc  = (n.rv != 0);
            n.rdy = s.cam;
            n.rv  = 1;
            n.cam = lowest_free(nb, n.vga, s.cam);
        end
        if (clr) begin
            n.drop = 0; n.rep = 0;
        end else begin
            if (dinc && n.drop < cmax) n.drop++;
            if (rinc && n.rep < cmax) n.rep++;
        end
        return n;
    endfunction

    mst_t m_a, m_b;
    int   cyc_a, cyc_b;
    int   wq_a[$], rq_a[$], wq_b[$], rq_b[$];
    bit   pw_a, pr_a, pw_b, pr_b, ew_a, er_a, ew_b, er_b;

    // Each sampled rising edge becomes an event SYNC_STAGES cycles later
    initial forever begin
        @(posedge clk or negedge rst_a);
        if (!rst_a) begin
            m_a = reset_state(); cyc_a = 0; wq_a.delete(); rq_a.delete(); pw_a = 0; pr_a = 0;
        end else begin
            cyc_a++;
            ew_a = (wq_a.size() > 0 && wq_a[0] == cyc_a);
            if (ew_a) void'(wq_a.pop_front());
            er_a = (rq_a.size() > 0 && rq_a[0] == cyc_a);
            if (er_a) void'(rq_a.pop_front());
            m_a = step(m_a, ew_a, er_a, frz_a, clr_a, 3, 65535);
            if (cam_a && !pw_a) wq_a.push_back(cyc_a + S_A);
            if (vga_a && !pr_a) rq_a.push_back(cyc_a + S_A);
            pw_a = cam_a; pr_a = vga_a;
        end
    end

    initial forever begin
        @(posedge clk or negedge rst_b);
        if (!rst_b) begin
            m_b = reset_state(); cyc_b = 0; wq_b.delete(); rq_b.delete(); pw_b = 0; pr_b = 0;
        end else begin
            cyc_b++;
            ew_b = (wq_b.size() > 0 && wq_b[0] == cyc_b);
            if (ew_b) void'(wq_b.pop_front());
            er_b = (rq_b.size() > 0 && rq_b[0] == cyc_b);
            if (er_b) void'(rq_b.pop_front());
            m_b = step(m_b, ew_b, er_b, frz_b, clr_b, 5, 3);
            if (cam_b && !pw_b) wq_b.push_back(cyc_b + S_B);
            if (vga_b && !pr_b) rq_b.push_back(cyc_b + S_B);
            pw_b = cam_b; pr_b = vga_b;
        end
    end

    task automatic cmp(input string u, input mst_t m, input int nb, input int vga, input int cam,
                       input int rv, input int rdy, input int vnew, input int drop, input int rep);
        chk({u, " vga_bank"}, vga, m.vga);
        chk({u, " cam_bank"}, cam, m.cam);
        chk({u, " ready_valid"}, rv, m.rv);
        if (m.rv != 0) chk({u, " ready_bank"}, rdy, m.rdy);
        chk({u, " vga_new"}, vnew, m.vnew);
        chk({u, " drop_cnt"}, drop, m.drop);
        chk({u, " repeat_cnt"}, rep, m.rep);
        chk({u, " inv vga!=cam"}, 32'(vga != cam), 1);
        if (rv != 0) chk({u, " inv ready distinct"}, 32'(rdy != vga && rdy != cam), 1);
        chk({u, " inv range"}, 32'(vga < nb && cam < nb && rdy < nb), 1);
    endtask

    int vn_a = 0, vn_b = 0;
    initial forever begin
        @(negedge clk);
        if (vnew_a === 1'b1) vn_a++;
        if (vnew_b === 1'b1) vn_b++;
        if (cmp_en) begin
            cmp("A", m_a, 3, vga_bank_a, cam_bank_a, rv_a, rdy_bank_a, vnew_a, drop_a, rep_a);
            cmp("B", m_b, 5, vga_bank_b, cam_bank_b, rv_b, rdy_bank_b, vnew_b, drop_b, rep_b);
        end
    end

    task automatic do_reset(input int u);
        @(negedge clk);
        if (u == 0) rst_a = 1'b0; else rst_b = 1'b0;
        repeat (2) @(negedge clk);
        if (u == 0) rst_a = 1'b1; else rst_b = 1'b1;
        @(negedge clk);
    endtask

    task automatic pulse(input int u, input bit cam, input bit vga);
        @(negedge clk);
        if (u == 0) begin cam_a = cam; vga_a = vga; end
        else        begin cam_b = cam; vga_b = vga; end
        repeat (HOLD) @(negedge clk);
        cam_a = 1'b0; vga_a = 1'b0; cam_b = 1'b0; vga_b = 1'b0;
        repeat (GAP) @(negedge clk);
    endtask

    int v0;
    initial begin
        repeat (3) @(negedge clk);
        rst_a = 1'b1; rst_b = 1'b1;
        @(negedge clk);
        cmp_en = 1'b1;

        // Reset state
        chk("A rst vga", vga_bank_a, 0); chk("A rst cam", cam_bank_a, 1);
        chk("A rst rv", rv_a, 0);        chk("A rst rdy", rdy_bank_a, 0);
        chk("A rst vnew", vnew_a, 0);    chk("A rst drop", drop_a, 0);
        chk("A rst rep", rep_a, 0);

        // Three frames, no reader
        pulse(0, 1, 0); chk("A f1 cam", cam_bank_a, 2); chk("A f1 rdy", rdy_bank_a, 1);
        pulse(0, 1, 0); chk("A f2 cam", cam_bank_a, 1); chk("A f2 rdy", rdy_bank_a, 2);
        pulse(0, 1, 0); chk("A f3 cam", cam_bank_a, 2); chk("A f3 rdy", rdy_bank_a, 1);
        chk("A f3 drop", drop_a, 2); chk("A f3 vga", vga_bank_a, 0);

        // Frame then read
        do_reset(0);
        pulse(0, 1, 0);
        chk("A fr rv", rv_a, 1); chk("A fr rdy", rdy_bank_a, 1); chk("A fr cam", cam_bank_a, 2);
        v0 = vn_a;
        pulse(0, 0, 1);
        chk("A fr vga", vga_bank_a, 1); chk("A fr rv0", rv_a, 0);
        chk("A fr rep", rep_a, 0); chk("A fr vnew pulses", vn_a - v0, 1);

        // Reads with nothing ready
        do_reset(0);
        v0 = vn_a;
        pulse(0, 0, 1); pulse(0, 0, 1);
        chk("A rr vga", vga_bank_a, 0); chk("A rr rep", rep_a, 2);
        chk("A rr vnew pulses", vn_a - v0, 0);

        // Simultaneous read and write
        do_reset(0);
        pulse(0, 1, 0);
        pulse(0, 1, 1);
        chk("A sim vga", vga_bank_a, 1); chk("A sim rdy", rdy_bank_a, 2);
        chk("A sim cam", cam_bank_a, 0); chk("A sim rv", rv_a, 1); chk("A sim drop", drop_a, 0);

        // Input held high gives one event
        do_reset(0);
        @(negedge clk); cam_a = 1'b1;
        repeat (20) @(negedge clk); cam_a = 1'b0;
        repeat (GAP) @(negedge clk);
        chk("A hold rdy", rdy_bank_a, 1); chk("A hold cam", cam_bank_a, 2);
        chk("A hold drop", drop_a, 0);

        // Five banks, frozen reader
        do_reset(1);
        frz_b = 1'b1;
        pulse(1, 1, 0); chk("B fz1 cam", cam_bank_b, 2);
        pulse(1, 1, 0); chk("B fz2 cam", cam_bank_b, 1);
        pulse(1, 1, 0); chk("B fz3 cam", cam_bank_b, 2);
        pulse(1, 1, 0); chk("B fz4 cam", cam_bank_b, 1);
        pulse(1, 0, 1);
        chk("B fz vga", vga_bank_b, 0); chk("B fz drop", drop_b, 3); chk("B fz rep", rep_b, 0);
        frz_b = 1'b0;
        pulse(1, 0, 1);
        chk("B unfz vga", vga_bank_b, 2);

        // Saturation, clear priority, async reset
        do_reset(1);
        for (int i = 0; i < 5; i++) pulse(1, 0, 1);
        chk("B sat rep", rep_b, 3);
        @(negedge clk); vga_b = 1'b1; clr_b = 1'b1;
        repeat (HOLD) @(negedge clk); vga_b = 1'b0; clr_b = 1'b0;
        repeat (GAP) @(negedge clk);
        chk("B clr rep", rep_b, 0);
        pulse(1, 1, 0); pulse(1, 0, 1); pulse(1, 1, 0);
        @(negedge clk); vga_b = 1'b1;
        repeat (2) @(negedge clk);
        #2 rst_b = 1'b0; vga_b = 1'b0;
        #1;
        chk("B arst vga", vga_bank_b, 0); chk("B arst cam", cam_bank_b, 1);
        chk("B arst rv", rv_b, 0);        chk("B arst rdy", rdy_bank_b, 0);
        chk("B arst vnew", vnew_b, 0);    chk("B arst drop", drop_b, 0);
        chk("B arst rep", rep_b, 0);
        repeat (2) @(negedge clk);
        rst_b = 1'b1;
        repeat (GAP) @(negedge clk);
        chk("B lost ev rep", rep_b, 0); chk("B lost ev vga", vga_bank_b, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
